apb_master_n: RTL and testbench
===============================

// Module: apb_master_n
// PURPOSE
//  Parametrised APB3 bridge between the RV32I core data port and NUM_SLV peripherals.
//  - Decodes the core address into a one-hot PSEL vector and runs the SETUP/ACCESS sequence.
//  - Returns read data and a one-cycle completion pulse to the core.
//  - New over the fixed 4-slave bridge: configurable slot map, PREADY timeout, error reporting.
//  Sits in the MCU top between RV32I_Core and RAM/GPO/GPI/UART peripherals.
// PARAMETERS
//  NUM_SLV    4             number of slave channels, 1..16
//  DATA_W     32            PWDATA/PRDATA width
//  ADDR_W     32            core/APB address width
//  BASE_ADDR  32'h1000_0000 start of peripheral window
//  SLOT_BITS  12            log2 bytes per slave slot (4 KB)
//  TIMEOUT    16            max ACCESS cycles with PREADY low; 0 = no timeout
// PORTS
//  PCLK       in   1               clock, rising edge
//  PRESET     in   1               reset, asynchronous, active-low
//  transfer   in   1               core request strobe, sampled in IDLE
//  write      in   1               1 = write, 0 = read
//  addr       in   ADDR_W          byte address
//  wdata      in   DATA_W          write data
//  rdata      out  DATA_W          read data, valid while ready=1
//  ready      out  1               one-cycle completion pulse
//  err        out  1               with ready: unmapped address or timeout
//  PADDR      out  ADDR_W          APB address (full latched addr)
//  PWDATA     out  DATA_W          APB write data
//  PWRITE     out  1               APB direction
//  PENABLE    out  1               APB access phase
//  PSEL       out  NUM_SLV         one-hot slave select
//  PRDATA     in   NUM_SLV*DATA_W  slave i data at [i*DATA_W +: DATA_W]
//  PREADY     in   NUM_SLV         per-slave ready
// BEHAVIOUR
//  Reset (PRESET=0, async): state=IDLE; all outputs 0; timeout counter 0.
//  FSM states:
//   IDLE: on transfer=1, latch addr/wdata/write and decode.
//    - mapped -> SETUP
//    - unmapped -> ERR
//   SETUP: PSEL[idx]=1, PENABLE=0; go to ACCESS.
//   ACCESS: PSEL[idx]=1, PENABLE=1.
//    - PREADY[idx]=1 -> DONE; latch rdata = PRDATA slice for reads, 0 for writes.
//    - otherwise the counter increments; at count==TIMEOUT-1 with PREADY low -> DONE, err=1, rdata=0.
//   ERR: no PSEL asserted; go to DONE with err=1, rdata=0.
//   DONE: ready=1 for exactly one cycle, err valid, PSEL=0, PENABLE=0.
//    - transfer=1 in DONE is accepted like IDLE (back-to-back).
//    - otherwise -> IDLE.
//  Decode:
//   - off = addr - BASE_ADDR; idx = off >> SLOT_BITS.
//   - mapped iff addr >= BASE_ADDR and idx < NUM_SLV.
//  Bus stability: PADDR/PWDATA/PWRITE come from registers, stable SETUP through ACCESS.
//   - They hold their last value when idle; PSEL/PENABLE drop to 0.
//  Latency: zero-wait access = request cycle + SETUP + ACCESS; ready in the 4th cycle (DONE).
//  Other rules:
//   - transfer in SETUP/ACCESS/ERR is ignored; the core holds it until ready.
//   - PREADY of non-selected slaves and PREADY during SETUP are ignored.
//   - rdata/err are held until the next completion; ready is 0 outside DONE.
//   - Reset mid-transfer aborts immediately; no ready is issued.
// STRUCTURE
//  apb_pkg:
//   - typedef enum {IDLE,SETUP,ACCESS,ERR,DONE} apb_state_e
//   - localparam APB_DEF_BASE = 32'h1000_0000
//  Sub-module apb_addr_decoder (combinational):
//   - inputs: addr
//   - outputs: idx, mapped, psel_onehot
//   - parametrised by NUM_SLV, BASE_ADDR, SLOT_BITS
//  The FSM, timeout counter and data mux stay in apb_master_n.
// TESTING
//  1. Zero-wait write: transfer, write=1, addr=32'h1000_1004, wdata=32'hA5 ->
//     PSEL=4'b0010, PENABLE in the 3rd cycle, ready=1, err=0 in the 4th.
//  2. Read with 2 wait states from slave 2 (PRDATA=32'h1234_5678) ->
//     ready in the 6th cycle, rdata=32'h1234_5678, PADDR stable throughout.
//  3. Unmapped addr=32'h2000_0000 -> PSEL stays 0, ready=1, err=1 two cycles after the request.
//  4. Slave 3 never ready, TIMEOUT=16 -> PENABLE high 16 cycles, then ready=1, err=1, rdata=0.
//  5. Back-to-back: transfer held through DONE -> next SETUP immediately follows DONE.
//  6. PRESET low during ACCESS -> PSEL=0, PENABLE=0, ready=0 without a clock edge.
//     After release the FSM is in IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB3 bridge: FSM states, default window base
// and a width helper used by the decoder and the timeout counter.
package apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR,
        DONE
    } apb_state_e;

    localparam logic [31:0] APB_DEF_BASE = 32'h1000_0000;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slot decoder: core byte address -> slave index,
// mapped flag and one-hot select vector.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                NUM_SLV   = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(APB_DEF_BASE),
    parameter int                SLOT_BITS = 12,
    parameter int                IDX_W     = idx_w(NUM_SLV)
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [IDX_W-1:0]   idx,
    output logic               mapped,
    output logic [NUM_SLV-1:0] psel_onehot
);

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] slot;

    always_comb begin
        off         = addr - BASE_ADDR;
        slot        = off >> SLOT_BITS;
        // below the window the subtraction wraps, so the lower bound is explicit
        mapped      = (addr >= BASE_ADDR) && (slot < ADDR_W'(NUM_SLV));
        idx         = slot[IDX_W-1:0];
        psel_onehot = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            psel_onehot[i] = mapped && (slot == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/apb_master_n.sv
// APB3 bridge between the core data port and NUM_SLV peripherals,
// with slot decoding, PREADY timeout and error completion.
module apb_master_n
    import apb_pkg::*;
#(
    parameter int                NUM_SLV   = 4,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(APB_DEF_BASE),
    parameter int                SLOT_BITS = 12,
    parameter int                TIMEOUT   = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       transfer,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       ready,
    output logic                       err,
    output logic [ADDR_W-1:0]          PADDR,
    output logic [DATA_W-1:0]          PWDATA,
    output logic                       PWRITE,
    output logic                       PENABLE,
    output logic [NUM_SLV-1:0]         PSEL,
    input  logic [NUM_SLV*DATA_W-1:0]  PRDATA,
    input  logic [NUM_SLV-1:0]         PREADY
);

    localparam int IDX_W = idx_w(NUM_SLV);
    localparam int CNT_W = idx_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    apb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic [NUM_SLV-1:0] sel_q, sel_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [IDX_W-1:0]   dec_idx;
    logic               dec_mapped;
    logic [NUM_SLV-1:0] dec_psel;
    logic               pready_sel;
    logic [DATA_W-1:0]  prdata_sel;

    apb_addr_decoder #(
        .NUM_SLV   (NUM_SLV),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_BITS (SLOT_BITS),
        .IDX_W     (IDX_W)
    ) u_dec (
        .addr        (addr),
        .idx         (dec_idx),
        .mapped      (dec_mapped),
        .psel_onehot (dec_psel)
    );

    assign pready_sel = PREADY[idx_q];
    assign prdata_sel = PRDATA[int'(idx_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        sel_d    = sel_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (transfer) begin
                    paddr_d  = addr;
                    pwdata_d = wdata;
                    pwrite_d = write;
                    sel_d    = dec_psel;
                    idx_d    = dec_idx;
                    state_d  = dec_mapped ? SETUP : ERR;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready_sel) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = pwrite_q ? '0 : prdata_sel;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                state_d = DONE;
                err_d   = 1'b1;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            sel_q    <= '0;
            idx_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            sel_q    <= sel_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // selects are only driven while a slave is being addressed
    assign PSEL    = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
    assign PENABLE = (state_q == ACCESS);
    assign ready   = (state_q == DONE);
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;

endmodule

// File: tb/tb_apb_master_n.sv
// Self-checking bench for apb_master_n: directed vector table,
// reset-abort sequence and randomized traffic vs a timeline model.
module tb_apb_master_n;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          TMO  = 16;

    logic         PCLK = 1'b0;
    logic         PRESET;
    logic         transfer;
    logic         write;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ready;
    logic         err;
    logic [31:0]  PADDR;
    logic [31:0]  PWDATA;
    logic         PWRITE;
    logic         PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_rdata, exp_paddr, exp_pwdata;
    logic        exp_err, exp_pwrite;

    apb_master_n dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        int          nwait;
        bit          b2b;
        logic [3:0]  e_sel;
        bit          e_err;
        int          e_last;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, expv);
        end
    endtask

    task automatic chk_bus();
        chk("paddr", PADDR, exp_paddr);
        chk("pwdata", PWDATA, exp_pwdata);
        chk("pwrite", 32'(PWRITE), 32'(exp_pwrite));
        chk("rdata", rdata, exp_rdata);
        chk("err", 32'(err), 32'(exp_err));
    endtask

    task automatic idle(input int k);
        transfer = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            chk("idle_ready", 32'(ready), 32'd0);
            chk("idle_psel", 32'(PSEL), 32'd0);
            chk("idle_penable", 32'(PENABLE), 32'd0);
            chk_bus();
            addr   = $urandom;
            wdata  = $urandom;
            write  = 1'($urandom);
            PREADY = 4'($urandom);
        end
    endtask

    // Called at a negedge with the DUT idle or in DONE.
    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input int nwait, input bit b2b,
                       input logic [3:0] e_sel, input bit e_err,
                       input int e_last, input logic [31:0] e_rdata);
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++) if (e_sel[i]) idx = i;
        transfer = 1'b1;
        write    = w;
        addr     = a;
        wdata    = d;
        for (int i = 0; i < 4; i++) PRDATA[i*32 +: 32] = $urandom;
        if (e_sel != 4'd0) PRDATA[idx*32 +: 32] = rd;
        PREADY     = 4'($urandom);
        exp_paddr  = a;
        exp_pwdata = d;
        exp_pwrite = w;
        for (int n = 1; n <= e_last; n++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (n == e_last) begin
                exp_rdata = e_rdata;
                exp_err   = e_err;
            end
            chk("ready", 32'(ready), 32'(n == e_last));
            chk("psel", 32'(PSEL), (n == e_last) ? 32'd0 : 32'(e_sel));
            chk("penable", 32'(PENABLE),
                32'((n != e_last) && (e_sel != 4'd0) && (n >= 2)));
            chk_bus();
            addr   = $urandom;
            wdata  = $urandom;
            write  = 1'($urandom);
            PREADY = 4'($urandom);
            if (e_sel != 4'd0 && n >= 2 && n != e_last)
                PREADY[idx] = ((n - 2) >= nwait);
            if (n == e_last) transfer = b2b;
        end
    endtask

    task automatic model(input bit w, input logic [31:0] a,
                         input logic [31:0] rd, input int nwait,
                         output logic [3:0] e_sel, output bit e_err,
                         output int e_last, output logic [31:0] e_rdata);
        bit          mapped;
        logic [31:0] slot;
        int          acc;
        slot   = (a - BASE) / 32'd4096;
        mapped = (a >= BASE) && (slot < 32'd4);
        e_sel  = mapped ? 4'(1 << slot) : 4'd0;
        acc    = (nwait < TMO) ? nwait + 1 : TMO;
        e_err  = !mapped || (nwait >= TMO);
        e_last = mapped ? 2 + acc : 2;
        e_rdata = (w || e_err) ? 32'd0 : rd;
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h1000_1004, 32'h0000_00A5, 32'h0, 0, 1'b0,
                   4'b0010, 1'b0, 3, 32'h0};
        tbl[1] = '{1'b0, 32'h1000_2010, 32'h0, 32'h1234_5678, 2, 1'b0,
                   4'b0100, 1'b0, 5, 32'h1234_5678};
        tbl[2] = '{1'b0, 32'h2000_0000, 32'h0, 32'h0, 0, 1'b0,
                   4'b0000, 1'b1, 2, 32'h0};
        tbl[3] = '{1'b0, 32'h1000_3000, 32'h0, 32'hDEAD_BEEF, 1000, 1'b0,
                   4'b1000, 1'b1, 18, 32'h0};
        tbl[4] = '{1'b0, 32'h1000_0008, 32'h0, 32'hCAFE_F00D, 0, 1'b1,
                   4'b0001, 1'b0, 3, 32'hCAFE_F00D};
        tbl[5] = '{1'b1, 32'h1000_3FFC, 32'h0000_5A5A, 32'h0, 1, 1'b1,
                   4'b1000, 1'b0, 4, 32'h0};
        tbl[6] = '{1'b0, 32'h0FFF_FFFC, 32'h0, 32'h0, 0, 1'b1,
                   4'b0000, 1'b1, 2, 32'h0};
        tbl[7] = '{1'b0, 32'h1000_4000, 32'h0, 32'h0, 0, 1'b0,
                   4'b0000, 1'b1, 2, 32'h0};
        tbl[8] = '{1'b0, 32'h1000_0FFC, 32'h0, 32'h0BAD_F00D, 15, 1'b0,
                   4'b0001, 1'b0, 18, 32'h0BAD_F00D};
        tbl[9] = '{1'b1, 32'h1000_2000, 32'h0000_0077, 32'h0, 16, 1'b0,
                   4'b0100, 1'b1, 18, 32'h0};

        PRESET   = 1'b0;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = '0;
        wdata    = '0;
        PRDATA   = '0;
        PREADY   = '0;
        exp_rdata  = '0;
        exp_err    = 1'b0;
        exp_paddr  = '0;
        exp_pwdata = '0;
        exp_pwrite = 1'b0;

        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk_bus();
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1;
        idle(2);

        foreach (tbl[i]) begin
            txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].nwait,
                tbl[i].b2b, tbl[i].e_sel, tbl[i].e_err, tbl[i].e_last,
                tbl[i].e_rdata);
            if (!tbl[i].b2b) idle(1);
        end

        // reset asserted in the middle of an ACCESS phase
        transfer = 1'b1;
        write    = 1'b0;
        addr     = 32'h1000_1000;
        PREADY   = 4'd0;
        @(posedge PCLK);
        @(posedge PCLK);
        #2;
        chk("pre_rst_penable", 32'(PENABLE), 32'd1);
        PRESET = 1'b0;
        #1;
        chk("arst_psel", 32'(PSEL), 32'd0);
        chk("arst_penable", 32'(PENABLE), 32'd0);
        chk("arst_ready", 32'(ready), 32'd0);
        exp_rdata  = '0;
        exp_err    = 1'b0;
        exp_paddr  = '0;
        exp_pwdata = '0;
        exp_pwrite = 1'b0;
        chk_bus();
        transfer = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b1;
        idle(2);
        txn(tbl[0].w, tbl[0].a, tbl[0].d, tbl[0].rd, tbl[0].nwait, 1'b0,
            tbl[0].e_sel, tbl[0].e_err, tbl[0].e_last, tbl[0].e_rdata);
        idle(1);

        for (int it = 0; it < 40; it++) begin
            bit          w, b2b;
            logic [31:0] a, d, rd, e_rdata;
            logic [3:0]  e_sel;
            bit          e_err;
            int          nwait, e_last, r;
            w  = 1'($urandom);
            d  = $urandom;
            rd = $urandom;
            r  = $urandom_range(0, 9);
            if (r < 7)
                a = BASE + 32'($urandom_range(0, 3)) * 32'h1000
                    + ($urandom & 32'h0000_0FFC);
            else if (r == 7)
                a = BASE + 32'h4000 + ($urandom & 32'h0000_0FFC);
            else if (r == 8)
                a = BASE - 32'($urandom_range(1, 64)) * 4;
            else
                a = $urandom;
            nwait = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20)
                                                : $urandom_range(0, 3);
            b2b = (it < 39) && 1'($urandom);
            model(w, a, rd, nwait, e_sel, e_err, e_last, e_rdata);
            txn(w, a, d, rd, nwait, b2b, e_sel, e_err, e_last, e_rdata);
            if (!b2b) idle($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
